// File: rtl/i2c_pkg.sv
// Shared I2C types: slave FSM states, ACK/NACK line levels and master command codes.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, WAIT_STOP
  } slave_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [1:0] {
    M_IDLE, M_START, M_XFER, M_STOP
  } master_cmd_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus registered SCL edge and START/STOP flags.
// The sda output is aligned with the flags, so it is the bit value at the SCL rise.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic areset_n,
  input  logic scl_di,
  input  logic sda_di,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign sda   = sda_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_di};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_di};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      scl_rise <= scl_s & ~scl_d;
      scl_fall <= ~scl_s & scl_d;
      // SDA moving while SCL is held high is never data
      start    <= scl_s & scl_d & sda_d & ~sda_s;
      stop     <= scl_s & scl_d & ~sda_d & sda_s;
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// Write-only I2C slave capturing a 16-bit register address (high byte, then low byte).
// Reads, wrong addresses and extra bytes are NACKed; the block never drives data.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h42,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        scl_di,
  input  logic        sda_di,
  output logic        sda_do,
  output logic [15:0] register_address,
  output logic        register_valid,
  output logic        busy
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .scl_di   (scl_di),
    .sda_di   (sda_di),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  slave_state_e state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [7:0]  shreg, shreg_n, byte_in;
  logic [15:0] stage, stage_n, addr_n;
  logic        ack_drv, ack_n, valid_n;

  assign byte_in = {shreg[6:0], sda};
  assign sda_do  = ack_drv ? ACK : NACK;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      shreg            <= '0;
      stage            <= '0;
      ack_drv          <= 1'b0;
      register_address <= '0;
      register_valid   <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      shreg            <= shreg_n;
      stage            <= stage_n;
      ack_drv          <= ack_n;
      register_address <= addr_n;
      register_valid   <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    stage_n = stage;
    ack_n   = ack_drv;
    addr_n  = register_address;
    valid_n = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      ack_n   = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      ack_n   = 1'b0;
    end else begin
      case (state)
        ADDR, BYTE_HI, BYTE_LO: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            case (state)
              ADDR:    state_n = (byte_in[7:1] == SLAVE_ADDRESS && !byte_in[0]) ? ACK_ADDR : WAIT_STOP;
              BYTE_HI: begin stage_n[15:8] = byte_in; state_n = ACK_HI; end
              default: begin stage_n[7:0]  = byte_in; state_n = ACK_LO; end
            endcase
          end
        end
        // first SCL fall after the 8th bit pulls SDA low, the next one releases it
        ACK_ADDR, ACK_HI, ACK_LO: if (scl_fall) begin
          if (!ack_drv) ack_n = 1'b1;
          else begin
            ack_n = 1'b0;
            case (state)
              ACK_ADDR: state_n = BYTE_HI;
              ACK_HI:   state_n = BYTE_LO;
              default: begin
                state_n = WAIT_STOP;
                addr_n  = stage;
                valid_n = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h42, the 7-bit bus address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA (minimum 2).
REQ-003 clk  input  1  system clock; one clock domain; the block SHALL use no other clock.
REQ-004 areset_n  input  1  asynchronous active-low reset.
REQ-005 scl_di  input  1  SCL pad input; asynchronous to clk.
REQ-006 sda_di  input  1  SDA pad input; asynchronous to clk.
REQ-007 sda_do  output  1  SDA open-drain drive: 0 = pull low, 1 = release.
REQ-008 register_address  output  16  last complete register address received, MSB first.
REQ-009 register_valid  output  1  one-clk pulse when register_address updates.
REQ-010 busy  output  1  high from the START condition until the STOP condition or an abort.

Function
REQ-011 SCL and SDA SHALL each pass through SYNC_STAGES flops; all decisions SHALL use only synchronized values and their one-clk-delayed copies.
REQ-012 START condition: synchronized SDA falls while synchronized SCL is high; STOP condition: SDA rises while SCL is high; detection latency SHALL be SYNC_STAGES+1 clk.
REQ-013 Data bits SHALL be sampled on the synchronized SCL rising edge and shifted in MSB first.
REQ-014 FSM states: IDLE, ADDR, ACK_ADDR, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, WAIT_STOP.
REQ-015 A START from any state SHALL set bit count to 0, assert busy and enter ADDR (a repeated START aborts the transfer in progress and discards the partial address).
REQ-016 A STOP from any state SHALL enter IDLE and deassert busy.
REQ-017 ADDR: after the 8th bit, if bits[7:1] == SLAVE_ADDRESS and bit0 == 0 (write), the FSM SHALL go to ACK_ADDR; otherwise it SHALL go to WAIT_STOP with sda_do held at 1 (NACK).
REQ-018 ACK_x states: sda_do SHALL go to 0 on the first SCL falling edge after the 8th bit and SHALL be released to 1 on the next SCL falling edge.
REQ-019 ACK_x sequencing: ACK_ADDR leads to BYTE_HI, ACK_HI leads to BYTE_LO, and ACK_LO leads to WAIT_STOP.
REQ-020 The high byte SHALL be written into a staging register, and the low byte SHALL complete it.
REQ-021 On the ACK_LO release edge, register_address SHALL load the staging value and register_valid SHALL pulse for exactly 1 clk.
REQ-022 WAIT_STOP: any further bytes SHALL be NACKed (sda_do stays 1) and ignored until a STOP or START arrives.
REQ-023 A read request (R/W = 1) SHALL be NACKed; the block SHALL never drive data onto the bus.
REQ-024 sda_do SHALL be 0 only in ACK states during the SCL-low/high window defined in REQ-018; it SHALL be 1 in all other states.
REQ-025 An SDA change while SCL is high inside a byte SHALL be treated only as START or STOP, never as data.

Reset
REQ-026 While areset_n = 0: sda_do = 1, register_address = 16'h0000, register_valid = 0, busy = 0, FSM = IDLE, and synchronizer flops = 1.
REQ-027 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and discard the partial data.
REQ-028 After reset release the block SHALL ignore the bus until the next START.

Structure
REQ-029 The FSM state enum and the ACK/NACK constants SHALL live in the shared package i2c_pkg, alongside the master's types.
REQ-030 START/STOP and edge detection SHALL be one sub-module, i2c_bus_sync, containing the synchronizers, edge detection and start/stop flags; it SHALL be reusable by the master.

Verification
REQ-031 Write transfer: START, 0x84, 0xA5, 0x5A, STOP -> three ACKs, register_address = 16'hA55A, one register_valid pulse, busy drops after STOP.
REQ-032 Wrong address: START, 0x86, STOP -> no ACK (sda_do always 1), no register_valid, register_address unchanged.
REQ-033 Read request: START, 0x85 -> NACK, and the FSM is in WAIT_STOP until STOP.
REQ-034 Repeated START after the high byte 0x12 then full write 0x84, 0x34, 0x56 -> register_address = 16'h3456, exactly one valid pulse.
REQ-035 Third byte 0x77 after 16'hBEEF -> third byte NACKed, register_address stays 16'hBEEF.
REQ-036 Reset asserted during ACK_HI -> sda_do = 1 within the same clk, outputs at reset values, next clean write captured correctly.
